// File: rtl/rv_pkg.sv
// Shared types for the integer register writeback path: result entry and arbiter source select.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small in-order result buffer; one instance per producer feeding the writeback arbiter.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clr_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t din_i,
    output wb_entry_t dout_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/reg_writeback.sv
// Register bank writer: buffers ALU/LSU results, round-robins one registered write per cycle,
// and tracks in-flight destinations so decode can stall on busy operands.
module reg_writeback
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] query_rs1,
    input  logic [REG_AW-1:0] query_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              reg_we,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_val
);
    wb_entry_t         alu_head, lsu_head, head;
    logic              alu_full, alu_empty, lsu_full, lsu_empty;
    logic              alu_push, lsu_push, alu_pop, lsu_pop;
    src_e              rr_q, rr_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   val_q, val_d;
    logic [NREG-1:0]   sb_q, sb_d;

    assign alu_ready = !alu_full && !flush;
    assign lsu_ready = !lsu_full && !flush;
    assign alu_push  = alu_valid && alu_ready;
    assign lsu_push  = lsu_valid && lsu_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_i(clk), .rst_i(rst), .clr_i(flush),
        .push_i(alu_push), .pop_i(alu_pop),
        .din_i('{rd: alu_rd, data: alu_data}), .dout_o(alu_head),
        .full_o(alu_full), .empty_o(alu_empty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk_i(clk), .rst_i(rst), .clr_i(flush),
        .push_i(lsu_push), .pop_i(lsu_pop),
        .din_i('{rd: lsu_rd, data: lsu_data}), .dout_o(lsu_head),
        .full_o(lsu_full), .empty_o(lsu_empty)
    );

    always_comb begin
        alu_pop  = 1'b0;
        lsu_pop  = 1'b0;
        rr_d     = rr_q;
        head     = alu_head;
        if (!flush) begin
            if (!alu_empty && (lsu_empty || rr_q == SRC_ALU)) begin
                alu_pop = 1'b1;
                rr_d    = SRC_LSU;
            end else if (!lsu_empty) begin
                lsu_pop = 1'b1;
                head    = lsu_head;
                rr_d    = SRC_ALU;
            end
        end
        // x0 results are consumed but never reach the bank.
        reg_we_d = (alu_pop || lsu_pop) && (head.rd != '0);
        rd_d     = rd_q;
        val_d    = val_q;
        if (reg_we_d) begin
            rd_d  = head.rd;
            val_d = head.data;
        end
    end

    // A new issue to the register being written keeps it busy for the newer producer.
    always_comb begin
        sb_d = sb_q;
        if (reg_we_q)    sb_d[rd_q]     = 1'b0;
        if (issue_valid) sb_d[issue_rd] = 1'b1;
        sb_d[0] = 1'b0;
        if (flush)       sb_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= SRC_ALU;
            reg_we_q <= 1'b0;
            rd_q     <= '0;
            val_q    <= '0;
            sb_q     <= '0;
        end else begin
            rr_q     <= rr_d;
            reg_we_q <= reg_we_d;
            rd_q     <= rd_d;
            val_q    <= val_d;
            sb_q     <= sb_d;
        end
    end

    assign rs1_busy = sb_q[query_rs1];
    assign rs2_busy = sb_q[query_rs2];
    assign reg_we   = reg_we_q;
    assign rd       = rd_q;
    assign rd_val   = val_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes go into a queue, a negedge monitor checks them.
module tb_reg_writeback;
    import rv_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [REG_AW-1:0] alu_rd, lsu_rd, issue_rd, query_rs1, query_rs2, rd;
    logic [XLEN-1:0]   alu_data, lsu_data, rd_val;
    logic              issue_valid, rs1_busy, rs2_busy, reg_we;

    int        checks = 0;
    int        errors = 0;
    wb_entry_t exp_q[$];
    logic [XLEN-1:0] bank [NREG];

    reg_writeback #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_we(reg_we), .rd(rd), .rd_val(rd_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reg_we) bank[rd] <= rd_val;

    always @(negedge clk) begin
        if (reg_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d val=%h, expected no write", rd, rd_val);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if (rd !== e.rd || rd_val !== e.data) begin
                    errors++;
                    $display("FAIL write_order: got rd=%0d val=%h, expected rd=%0d val=%h",
                             rd, rd_val, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int na, nl;
        logic ta, tl;
        logic exp_lr [1:4];
        exp_lr[1] = 1'b1; exp_lr[2] = 1'b1; exp_lr[3] = 1'b0; exp_lr[4] = 1'b1;

        rst = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; query_rs1 = '0; query_rs2 = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rd_val", rd_val, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);

        // ALU only: one-cycle latency, no bypass
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        exp_q.push_back('{rd: 5'd5, data: 32'h1234});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("no_bypass", 32'(reg_we), 32'd0);
        tick();
        @(negedge clk);
        chk("alu_we", 32'(reg_we), 32'd1);
        chk("alu_rd", 32'(rd), 32'd5);
        chk("alu_val", rd_val, 32'h1234);
        tick();
        @(negedge clk);
        chk("bank_x5", bank[5], 32'h1234);
        chk("alu_we_drop", 32'(reg_we), 32'd0);

        // Contention with producer handshake; LSU backs up while ALU wins first
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rd: 5'd1, data: 32'hA0 + i});
            exp_q.push_back('{rd: 5'd2, data: 32'hB0 + i});
        end
        na = 0; nl = 0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc <= 4) chk($sformatf("lsu_ready_c%0d", cyc), 32'(lsu_ready), 32'(exp_lr[cyc]));
            ta = alu_valid && alu_ready;
            tl = lsu_valid && lsu_ready;
            tick();
            if (ta) begin
                na++;
                if (na < 3) alu_data = 32'hA0 + 32'(na); else alu_valid = 1'b0;
            end
            if (tl) begin
                nl++;
                if (nl < 3) lsu_data = 32'hB0 + 32'(nl); else lsu_valid = 1'b0;
            end
        end
        chk("alu_sent", 32'(na), 32'd3);
        chk("lsu_sent", 32'(nl), 32'd3);
        chk("contention_drained", 32'(exp_q.size()), 32'd0);

        // Scoreboard set/clear, and re-issue during the write wins
        do_reset();
        query_rs1 = 5'd7; query_rs2 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        exp_q.push_back('{rd: 5'd7, data: 32'h77});
        @(negedge clk);
        chk("sb_set", 32'(rs1_busy), 32'd1);
        chk("sb_rs2_x0", 32'(rs2_busy), 32'd0);
        tick();
        alu_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("sb_busy_during_we", 32'(rs1_busy), 32'd1);
        chk("sb_we_rd7", 32'(reg_we), 32'd1);
        tick();
        @(negedge clk);
        chk("sb_clear", 32'(rs1_busy), 32'd0);
        tick();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        exp_q.push_back('{rd: 5'd7, data: 32'h78});
        tick();
        alu_valid = 1'b0;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("sb_reissue_we", 32'(reg_we), 32'd1);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("sb_reissue_wins", 32'(rs1_busy), 32'd1);

        // x0: no write pulse, never busy
        tick();
        query_rs1 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        tick();
        issue_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        tick();
        @(negedge clk);
        chk("x0_no_we", 32'(reg_we), 32'd0);
        tick();
        tick();

        // Flush with two buffered entries and x3/x4/x7 busy
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        flush = 1'b1;
        query_rs1 = 5'd3; query_rs2 = 5'd4;
        @(negedge clk);
        chk("flush_pre_busy", 32'(rs1_busy & rs2_busy), 32'd1);
        chk("flush_alu_ready", 32'(alu_ready), 32'd0);
        chk("flush_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy3", 32'(rs1_busy), 32'd0);
        chk("flush_busy4", 32'(rs2_busy), 32'd0);
        chk("flush_we", 32'(reg_we), 32'd0);
        query_rs1 = 5'd7;
        #1;
        chk("flush_busy7", 32'(rs1_busy), 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("flush_ready_back", 32'(alu_ready & lsu_ready), 32'd1);

        // Reset mid-stream: first write lands, buffered LSU entry and x9 pending are lost
        do_reset();
        query_rs1 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hBB;
        exp_q.push_back('{rd: 5'd10, data: 32'hAA});
        tick();
        issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy9", 32'(rs1_busy), 32'd1);
        tick();
        @(negedge clk);
        chk("mid_rst_we", 32'(reg_we), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        chk("mid_rst_val", rd_val, 32'd0);
        chk("mid_rst_busy", 32'(rs1_busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("mid_ready", 32'(alu_ready & lsu_ready), 32'd1);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
